// File: rtl/vd_acs_sched.sv
// Viterbi front-end sequencer: feeds symbol pairs to the BMC array, strobes the ACS
// array (init / normalization), addresses the survivor memory and launches traceback.
module vd_acs_sched #(
  parameter int unsigned TB_DEPTH = 64,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned ACS_LAT  = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [1:0]        rx_pair,
  input  logic              rx_last,
  output logic [1:0]        bmc_rx_pair,
  output logic              acs_en,
  output logic              acs_init,
  output logic              pm_norm,
  input  logic              pm_msb_any,
  output logic              sm_we,
  output logic [ADDR_W-1:0] sm_waddr,
  output logic              tb_start,
  output logic [ADDR_W-1:0] tb_addr,
  output logic [CNT_W-1:0]  tb_len,
  input  logic              tb_done,
  output logic              busy
);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StLaunch, StTrace} state_e;

  localparam int unsigned         BLANK_W    = $clog2(ACS_LAT + 2);
  localparam logic [BLANK_W-1:0]  BLANK_INIT = BLANK_W'(ACS_LAT + 1);
  localparam logic [CNT_W-1:0]    DEPTH_C    = CNT_W'(TB_DEPTH);

  state_e             state;
  logic [ADDR_W-1:0]  wptr;
  logic [CNT_W-1:0]   sym_cnt;
  logic               norm_pending;
  logic [BLANK_W-1:0] blank_cnt;
  logic [ACS_LAT-1:0] dly;

  logic accept;
  logic first;
  logic blank_active;
  logic dly_empty;
  logic take_norm;

  // Ready is decoded from state; forced low while reset is held.
  assign rx_ready     = ~rst & ((state == StIdle) | (state == StRun));
  assign accept       = rx_valid & rx_ready;
  assign first        = (state == StIdle);
  assign take_norm    = accept & ~first & norm_pending;
  // The pm_norm cycle itself is blanked, then ACS_LAT+1 further cycles.
  assign blank_active = pm_norm | (blank_cnt != '0);
  // Empty only once the strobe just issued has also shifted out.
  assign dly_empty    = ~acs_en & ~(|dly);
  assign sm_we        = dly[ACS_LAT-1];
  assign sm_waddr     = wptr;
  assign busy         = (state != StIdle);

  // Sequencer FSM plus all registered strobes, pointers and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      bmc_rx_pair  <= '0;
      acs_en       <= 1'b0;
      acs_init     <= 1'b0;
      pm_norm      <= 1'b0;
      tb_start     <= 1'b0;
      tb_addr      <= '0;
      tb_len       <= '0;
      wptr         <= '0;
      sym_cnt      <= '0;
      norm_pending <= 1'b0;
      blank_cnt    <= '0;
      dly          <= '0;
    end else begin
      acs_en   <= accept;
      acs_init <= accept & first;
      pm_norm  <= take_norm;
      tb_start <= 1'b0;
      if (accept) bmc_rx_pair <= rx_pair;

      dly[0] <= acs_en;
      for (int i = 1; i < ACS_LAT; i++) dly[i] <= dly[i-1];

      if (sm_we) wptr <= wptr + ADDR_W'(1);

      if (pm_norm) blank_cnt <= BLANK_INIT;
      else if (blank_cnt != '0) blank_cnt <= blank_cnt - BLANK_W'(1);

      // Consuming a pending request wins over a same-cycle re-arm.
      if (take_norm) norm_pending <= 1'b0;
      else if (pm_msb_any & ~blank_active) norm_pending <= 1'b1;

      if (accept) begin
        if (first) begin
          sym_cnt      <= CNT_W'(1);
          wptr         <= '0;
          norm_pending <= 1'b0;
          blank_cnt    <= '0;
        end else if (sym_cnt != '1) begin
          sym_cnt <= sym_cnt + CNT_W'(1);
        end
      end

      case (state)
        StIdle, StRun: begin
          if (accept) state <= rx_last ? StDrain : StRun;
        end
        StDrain: begin
          if (dly_empty) begin
            state    <= StLaunch;
            tb_start <= 1'b1;
            tb_addr  <= wptr - ADDR_W'(1);
            tb_len   <= (sym_cnt > DEPTH_C) ? DEPTH_C : sym_cnt;
          end
        end
        StLaunch: state <= StTrace;
        StTrace: begin
          if (tb_done) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/vd_acs_sched.md
Name: vd_acs_sched

Overview:
- Sequencer for the rate-1/2 Viterbi decoder front end.
- Accepts received 2-bit symbol pairs over a valid/ready stream and presents each pair to the 64-state BMC array.
- Issues ACS update strobes, including frame init and path-metric normalization, and generates survivor-memory write addresses.
- At end of frame it launches traceback and holds off new input until traceback completes.

Parameters:
TB_DEPTH, 64, survivor-memory depth in symbols; must be a power of 2
ADDR_W, 6, survivor-memory address width; equals log2(TB_DEPTH)
ACS_LAT, 2, cycles from acs_en to survivor decisions valid; range 1..8
CNT_W, 16, width of the frame symbol counter

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
rx_valid  in  1  input symbol valid
rx_ready  out  1  input symbol accepted when rx_valid & rx_ready
rx_pair  in  2  received hard-decision pair
rx_last  in  1  qualifies the final symbol of a frame
bmc_rx_pair  out  2  registered pair driving all BMC instances
acs_en  out  1  one-cycle ACS update strobe
acs_init  out  1  with acs_en: load initial metrics (state 0 = 0, others = max)
pm_norm  out  1  with acs_en: subtract normalization constant
pm_msb_any  in  1  OR of all path-metric MSBs from the ACS array
sm_we  out  1  survivor-memory write strobe
sm_waddr  out  ADDR_W  survivor-memory write address
tb_start  out  1  one-cycle traceback launch
tb_addr  out  ADDR_W  address of last survivor written
tb_len  out  CNT_W  symbols to trace back, min(sym_cnt, TB_DEPTH)
tb_done  in  1  traceback finished pulse
busy  out  1  high in any state other than IDLE

Behaviour:

Reset:
- Asynchronous on rst; state returns to IDLE.
- All outputs are 0, including rx_ready while rst is high.
- wptr, sym_cnt, norm_pending, the blanking counter and the delay line are cleared.
- A reset mid-frame aborts the frame. No tb_start is issued and no sm_we is generated for in-flight symbols.

States: IDLE, RUN, DRAIN, LAUNCH, TRACE.
- rx_ready = 1 in IDLE and RUN only; it is combinational from the state.

Acceptance and ACS issue:
- On an accepted symbol at cycle t, at t+1: bmc_rx_pair <= rx_pair and acs_en = 1.
- acs_init = 1 if the symbol is the first of the frame (accepted in IDLE). In that case wptr <= 0 and sym_cnt <= 1.
- Otherwise sym_cnt increments, saturating at 2^CNT_W-1.
- Throughput is one symbol per cycle; no bubbles are inserted.

Transitions:
- IDLE -> RUN on acceptance without rx_last.
- IDLE or RUN -> DRAIN on acceptance with rx_last. This covers single-symbol frames.

Survivor writes:
- A delay line of ACS_LAT stages tracks acs_en.
- sm_we is asserted exactly ACS_LAT cycles after each acs_en, with sm_waddr = wptr.
- After each write, wptr increments; it wraps from TB_DEPTH-1 to 0.

DRAIN:
- Hold until the delay line is empty, i.e. the last sm_we has been issued.
- Then -> LAUNCH.

LAUNCH (one cycle):
- tb_start = 1, tb_addr = wptr-1 mod TB_DEPTH, tb_len = min(sym_cnt, TB_DEPTH).
- Then -> TRACE.
- tb_addr and tb_len hold their values until the next LAUNCH.

TRACE:
- Wait for tb_done, then -> IDLE.
- tb_done in any other state is ignored.
- If tb_done arrives in the same cycle as tb_start, it is ignored.

Normalization:
- norm_pending is set when pm_msb_any = 1, sampled every cycle, unless blanking is active.
- On the next acs_en with acs_init = 0, pm_norm = 1 and norm_pending is cleared.
- After a pm_norm-tagged acs_en, pm_msb_any is blanked for ACS_LAT+1 cycles to prevent double normalization.
- acs_init overrides: an init update never carries pm_norm, and it clears norm_pending and blanking.

Constraints:
- acs_init and pm_norm are never high without acs_en.
- tb_start never coincides with acs_en.

Test Plan:
- Reset mid-frame: accept 10 symbols, assert rst for 1 cycle -> outputs 0 immediately. No tb_start follows. The next frame's first acs_en has acs_init = 1 and the first sm_waddr = 0.
- 5-symbol frame, pairs 00,01,10,11,00, rx_valid continuous, rx_last on the 5th:
  - 5 consecutive acs_en, the first with acs_init = 1.
  - sm_we with addresses 0..4, starting ACS_LAT cycles after the first acs_en.
  - tb_start once, with tb_addr = 4 and tb_len = 5.
  - rx_ready = 0 until tb_done, then 1.
- Wrap: 70-symbol frame -> sm_waddr sequence 0..63,0..5; tb_addr = 5, tb_len = 64.
- Normalization blanking: hold pm_msb_any = 1 continuously for 6 cycles mid-frame -> pm_norm on exactly one acs_en. A second pm_norm appears only if pm_msb_any is still 1 after the ACS_LAT+1 blanking window.
- Backpressure and gaps:
  - rx_valid toggling 1,0,1,0 -> acs_en only for accepted symbols, sm_we count equals accepted count.
  - Single-symbol frame (rx_last on first) -> acs_init with acs_en, tb_len = 1, tb_addr = 0.
- Spurious tb_done pulses in IDLE, RUN and DRAIN -> no state change. tb_done in TRACE -> IDLE next cycle, busy = 0.
